// File: rtl/h264enc_axi_slv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | h264enc_axi_slv_mem_pkg: shared AXI codes and types for the slave     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package h264enc_axi_slv_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;

  // WRAP is served as INCR, so only FIXED holds the address.
  function automatic logic burst_steps(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction

endpackage
`default_nettype wire

// File: rtl/h264enc_slv_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | h264enc_slv_ram: 1-port synchronous SRAM, byte enables, 1-cycle read  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module h264enc_slv_ram #(
  parameter int AW = 12,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            en,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < DW/8; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/h264enc_axi_slv_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | h264enc_axi_slv_mem: AXI3 slave responder on on-chip SRAM, one        |
// | transaction at a time. H264ENC_AXI_SLV_DECERR_EN adds a range check.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module h264enc_axi_slv_mem
  import h264enc_axi_slv_mem_pkg::*;
#(
  parameter int                AXI_DW    = 64,
  parameter int                AXI_AW    = 32,
  parameter int                AXI_SIDW  = 6,
  parameter int                MEM_AW    = 12,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0
) (
  input  logic                axi_clk,
  input  logic                axi_rst,
  input  logic [AXI_SIDW-1:0] awid,
  input  logic [AXI_AW-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [1:0]          awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [AXI_SIDW-1:0] wid,
  input  logic [AXI_DW-1:0]   wdata,
  input  logic [AXI_DW/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [AXI_SIDW-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [AXI_SIDW-1:0] arid,
  input  logic [AXI_AW-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [1:0]          arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [AXI_SIDW-1:0] rid,
  output logic [AXI_DW-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  state_e              state_q;
  logic                prio_wr_q, awready_q, arready_q, wready_q, bvalid_q;
  logic [AXI_SIDW-1:0] id_q;
  logic [MEM_AW-1:0]   word_q;
  logic [3:0]          len_q, wcnt_q, icnt_q;
  logic                incr_q, slverr_q, dec_q, issue_done_q;

  logic                infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0]          sk_cnt_q, sk_cnt_d;
  rbeat_t              sk0_q, sk0_d, sk1_q, sk1_d, push_beat;

  logic                grant_wr, grant_rd, g_incr, g_dec;
  logic [AXI_AW-1:0]   g_addr, g_off;
  logic [3:0]          g_len;
  logic [AXI_AW-4:0]   g_start;
`ifdef H264ENC_AXI_SLV_DECERR_EN
  logic [AXI_AW-3:0]   g_end;
`endif

  logic                wbeat, wbeat_last, rpop, issue, rd_active;
  logic [1:0]          occ;
  logic                ram_en;
  logic [AXI_DW/8-1:0] ram_we;
  logic [AXI_DW-1:0]   ram_rdata;

  // Arbitration and start/end word decode of the channel about to be granted.
  always_comb begin
    grant_wr = awvalid && (!arvalid || prio_wr_q);
    grant_rd = arvalid && !grant_wr;
    g_addr   = grant_wr ? awaddr : araddr;
    g_len    = grant_wr ? awlen  : arlen;
    g_incr   = burst_steps(grant_wr ? awburst : arburst);
    g_off    = g_addr - BASE_ADDR;
    g_start  = g_off[AXI_AW-1:3];
`ifdef H264ENC_AXI_SLV_DECERR_EN
    g_end    = {1'b0, g_start} + (AXI_AW-2)'(g_incr ? g_len : 4'd0);
    g_dec    = (|g_start[AXI_AW-4:MEM_AW]) || (|g_end[AXI_AW-3:MEM_AW]);
`else
    g_dec    = 1'b0;
`endif
  end

  assign rvalid     = sk_cnt_q != 2'd0;
  assign rpop       = rvalid && rready;
  assign wbeat      = (state_q == ST_WDATA) && wready_q && wvalid;
  assign wbeat_last = wcnt_q == len_q;
  assign rd_active  = (state_q == ST_RADDR) || (state_q == ST_RDATA);
  assign occ        = sk_cnt_q + {1'b0, infl_q};
  // Fetch only while the skid is guaranteed a free slot when the data lands.
  assign issue      = rd_active && !issue_done_q && ((occ < 2'd2) || rpop);

  assign ram_en = (wbeat || issue) && !dec_q;
  assign ram_we = wbeat ? wstrb : '0;

  h264enc_slv_ram #(.AW(MEM_AW), .DW(AXI_DW)) u_ram (
    .clk   (axi_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (word_q),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q      <= ST_IDLE;
      prio_wr_q    <= 1'b1;
      awready_q    <= 1'b0;
      arready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      id_q         <= '0;
      word_q       <= '0;
      len_q        <= '0;
      wcnt_q       <= '0;
      icnt_q       <= '0;
      incr_q       <= 1'b0;
      slverr_q     <= 1'b0;
      dec_q        <= 1'b0;
      issue_done_q <= 1'b0;
    end else begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_wr || grant_rd) begin
            prio_wr_q    <= !prio_wr_q;
            id_q         <= grant_wr ? awid : arid;
            word_q       <= g_start[MEM_AW-1:0];
            len_q        <= g_len;
            incr_q       <= g_incr;
            dec_q        <= g_dec;
            slverr_q     <= 1'b0;
            wcnt_q       <= '0;
            icnt_q       <= '0;
            issue_done_q <= 1'b0;
            if (grant_wr) begin
              awready_q <= 1'b1;
              wready_q  <= 1'b1;
              state_q   <= ST_WDATA;
            end else begin
              arready_q <= 1'b1;
              state_q   <= ST_RADDR;
            end
          end
        end
        ST_WDATA: begin
          if (wbeat) begin
            if (incr_q) word_q <= word_q + MEM_AW'(1);
            wcnt_q <= wcnt_q + 4'd1;
            if (wlast != wbeat_last) slverr_q <= 1'b1;
            if (wbeat_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              state_q  <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_RADDR, ST_RDATA: begin
          if (issue) begin
            if (incr_q) word_q <= word_q + MEM_AW'(1);
            icnt_q <= icnt_q + 4'd1;
            if (icnt_q == len_q) issue_done_q <= 1'b1;
          end
          state_q <= (rpop && sk0_q.last) ? ST_IDLE : ST_RDATA;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Two-entry skid: entry 0 is the head presented on R.
  always_comb begin
    infl_d      = issue;
    infl_last_d = issue && (icnt_q == len_q);
    push_beat   = '{data: dec_q ? '0 : ram_rdata,
                    last: infl_last_q,
                    resp: dec_q ? RESP_DECERR : RESP_OKAY};
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    sk_cnt_d = sk_cnt_q;
    case ({infl_q, rpop})
      2'b10: begin
        if (sk_cnt_q == 2'd0) sk0_d = push_beat;
        else                  sk1_d = push_beat;
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      2'b01: begin
        sk0_d    = sk1_q;
        sk_cnt_d = sk_cnt_q - 2'd1;
      end
      2'b11: begin
        if (sk_cnt_q == 2'd1) begin
          sk0_d = push_beat;
        end else begin
          sk0_d = sk1_q;
          sk1_d = push_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      sk_cnt_q    <= '0;
      sk0_q       <= '0;
      sk1_q       <= '0;
    end else begin
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      sk_cnt_q    <= sk_cnt_d;
      sk0_q       <= sk0_d;
      sk1_q       <= sk1_d;
    end
  end

  assign awready = awready_q;
  assign arready = arready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = id_q;
  assign bresp   = dec_q ? RESP_DECERR : (slverr_q ? RESP_SLVERR : RESP_OKAY);
  assign rid     = id_q;
  assign rdata   = sk0_q.data;
  assign rlast   = rvalid && sk0_q.last;
  assign rresp   = sk0_q.resp;

  logic unused_ok;
  assign unused_ok = ^{wid, awsize, arsize, awlock, awcache, awprot,
                       arlock, arcache, arprot, g_off[2:0], g_start};

endmodule
`default_nettype wire

// File: tb/tb_h264enc_axi_slv_mem.sv
`default_nettype none
// Directed bench for h264enc_axi_slv_mem: write/read bursts, arbitration,
// R back-pressure, byte strobes, wlast errors, address wrap/decode, reset.
module tb_h264enc_axi_slv_mem;

  localparam int         TMO    = 100;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic [5:0]  awid = '0, wid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [3:0]  awlen = '0, arlen = '0, awcache = '0, arcache = '0;
  logic [2:0]  awsize = 3'd3, arsize = 3'd3, awprot = '0, arprot = '0;
  logic [1:0]  awburst = '0, arburst = '0, awlock = '0, arlock = '0, bresp, rresp;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;
  logic [63:0] wdata = '0, rdata;
  logic [7:0]  wstrb = '0;

  int          tests = 0, fails = 0, other_rdy = 0;
  logic [63:0] wbuf [16];
  logic [63:0] exp_r [16];
  logic [63:0] rgot [16];

  always #5 clk = ~clk;

  h264enc_axi_slv_mem dut (
    .axi_clk(clk), .axi_rst(axi_rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_phase(input logic [5:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < TMO) begin
      if (arready === 1'b1) other_rdy++;
      @(posedge clk); #1; n++;
    end
    if (arready === 1'b1) other_rdy++;
    check("aw_ready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [3:0] len, input logic [7:0] strb, input int last_idx);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_idx); wvalid = 1'b1;
      while (wready !== 1'b1 && n < TMO) begin
        @(posedge clk); #1; n++;
      end
      check("w_ready", wready, 1'b1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase(input logic [5:0] id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    check("b_valid", bvalid, 1'b1);
    check("b_id", bid, id);
    check("b_resp", bresp, resp);
    check("b_no_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    bready = 1'b0;
    check("b_drop", bvalid, 1'b0);
  endtask

  task automatic ar_phase(input logic [5:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && n < TMO) begin
      if (awready === 1'b1) other_rdy++;
      @(posedge clk); #1; n++;
    end
    if (awready === 1'b1) other_rdy++;
    check("ar_ready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Entered one cycle after the AR handshake; collects len+1 beats.
  task automatic r_phase(input logic [3:0] len, input logic [5:0] id,
                         input logic [1:0] resp, input bit toggle);
    int          got = 0, cyc = 0;
    logic        stall = 1'b0;
    logic [63:0] pd = '0;
    check("r_lat1", rvalid, 1'b0);
    while (got <= int'(len) && cyc < TMO) begin
      rready = (toggle && cyc[0]) ? 1'b0 : 1'b1;
      if (cyc == 1) check("r_lat2", rvalid, 1'b1);
      if (stall) begin
        check("r_hold_valid", rvalid, 1'b1);
        check("r_hold_data", rdata, pd);
      end
      if (rvalid && rready) begin
        rgot[got] = rdata;
        check("r_id", rid, id);
        check("r_resp", rresp, resp);
        check("r_last", rlast, got == int'(len));
        got++;
        stall = 1'b0;
      end else begin
        stall = rvalid;
        pd    = rdata;
      end
      @(posedge clk); #1; cyc++;
    end
    rready = 1'b0;
    check("r_beats", got, int'(len) + 1);
    check("r_done", rvalid, 1'b0);
    for (int i = 0; i < got; i++) check("r_data", rgot[i], exp_r[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp}, 64'h0);
    check("reset_ids", {bid, rid}, 64'h0);
    check("reset_rdata", rdata, 64'h0);
    axi_rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic INCR write then readback
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h11 * (i + 1);
    aw_phase(6'h05, 32'h100, 4'd3, INCR);
    w_phase(4'd3, 8'hFF, 3);
    b_phase(6'h05, OKAY);
    for (int i = 0; i < 4; i++) exp_r[i] = 64'h11 * (i + 1);
    ar_phase(6'h09, 32'h100, 4'd3, INCR);
    r_phase(4'd3, 6'h09, OKAY, 1'b0);

    // 2: collisions; priority toggles on every grant
    other_rdy = 0;
    wbuf[0] = 64'hA5A5_0000_0000_0001;
    arid = 6'h21; araddr = 32'h100; arlen = 4'd0; arburst = INCR; arvalid = 1'b1;
    aw_phase(6'h20, 32'h200, 4'd0, INCR);
    w_phase(4'd0, 8'hFF, 0);
    b_phase(6'h20, OKAY);
    exp_r[0] = 64'h11;
    ar_phase(6'h21, 32'h100, 4'd0, INCR);
    r_phase(4'd0, 6'h21, OKAY, 1'b0);
    check("collide1_order", other_rdy, 0);

    wbuf[0] = 64'hA5A5_0000_0000_0002;
    arid = 6'h23; araddr = 32'h200; arlen = 4'd0; arburst = INCR; arvalid = 1'b1;
    aw_phase(6'h22, 32'h208, 4'd0, INCR);
    w_phase(4'd0, 8'hFF, 0);
    b_phase(6'h22, OKAY);
    exp_r[0] = 64'hA5A5_0000_0000_0001;
    ar_phase(6'h23, 32'h200, 4'd0, INCR);
    r_phase(4'd0, 6'h23, OKAY, 1'b0);
    check("collide2_order", other_rdy, 0);

    exp_r[0] = 64'hA5A5_0000_0000_0002;
    ar_phase(6'h24, 32'h208, 4'd0, INCR);
    r_phase(4'd0, 6'h24, OKAY, 1'b0);

    wbuf[0] = 64'hA5A5_0000_0000_0003;
    awid = 6'h26; awaddr = 32'h210; awlen = 4'd0; awburst = INCR; awvalid = 1'b1;
    exp_r[0] = 64'hA5A5_0000_0000_0002;
    ar_phase(6'h25, 32'h208, 4'd0, INCR);
    r_phase(4'd0, 6'h25, OKAY, 1'b0);
    check("collide3_read_first", other_rdy, 0);
    aw_phase(6'h26, 32'h210, 4'd0, INCR);
    w_phase(4'd0, 8'hFF, 0);
    b_phase(6'h26, OKAY);

    // 3: 16-beat read with rready toggling
    for (int i = 0; i < 16; i++) begin
      wbuf[i]  = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0001_0001_0001_0001;
      exp_r[i] = wbuf[i];
    end
    aw_phase(6'h30, 32'h400, 4'd15, INCR);
    w_phase(4'd15, 8'hFF, 15);
    b_phase(6'h30, OKAY);
    ar_phase(6'h31, 32'h400, 4'd15, INCR);
    r_phase(4'd15, 6'h31, OKAY, 1'b1);

    // 4: byte strobes, then FIXED burst overwriting one word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    aw_phase(6'h01, 32'h800, 4'd0, INCR);
    w_phase(4'd0, 8'hFF, 0);
    b_phase(6'h01, OKAY);
    wbuf[0] = 64'h0;
    aw_phase(6'h02, 32'h800, 4'd0, INCR);
    w_phase(4'd0, 8'h0F, 0);
    b_phase(6'h02, OKAY);
    exp_r[0] = 64'hFFFF_FFFF_0000_0000;
    ar_phase(6'h03, 32'h800, 4'd0, INCR);
    r_phase(4'd0, 6'h03, OKAY, 1'b0);

    wbuf[0] = 64'hAAAA; wbuf[1] = 64'hBBBB;
    aw_phase(6'h04, 32'h900, 4'd1, FIXED);
    w_phase(4'd1, 8'hFF, 1);
    b_phase(6'h04, OKAY);
    exp_r[0] = 64'hBBBB; exp_r[1] = 64'hBBBB;
    ar_phase(6'h05, 32'h900, 4'd1, FIXED);
    r_phase(4'd1, 6'h05, OKAY, 1'b0);

    // 5: early wlast -> all 4 beats taken, SLVERR
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h5000 + 64'(i);
    aw_phase(6'h0A, 32'hA00, 4'd3, INCR);
    w_phase(4'd3, 8'hFF, 1);
    check("slverr_wready_off", wready, 1'b0);
    b_phase(6'h0A, SLVERR);
    for (int i = 0; i < 4; i++) exp_r[i] = 64'h5000 + 64'(i);
    ar_phase(6'h0B, 32'hA00, 4'd3, INCR);
    r_phase(4'd3, 6'h0B, OKAY, 1'b0);

`ifdef H264ENC_AXI_SLV_DECERR_EN
    exp_r[0] = 64'h0; exp_r[1] = 64'h0;
    ar_phase(6'h0C, 32'h7FF8, 4'd1, INCR);
    r_phase(4'd1, 6'h0C, DECERR, 1'b0);
`else
    wbuf[0] = 64'hE0D0; wbuf[1] = 64'hE0D1;
    aw_phase(6'h0C, 32'h7FF8, 4'd1, INCR);
    w_phase(4'd1, 8'hFF, 1);
    b_phase(6'h0C, OKAY);
    exp_r[0] = 64'hE0D1;
    ar_phase(6'h0D, 32'h0, 4'd0, INCR);
    r_phase(4'd0, 6'h0D, OKAY, 1'b0);
    exp_r[0] = 64'hE0D0; exp_r[1] = 64'hE0D1;
    ar_phase(6'h0E, 32'h7FF8, 4'd1, INCR);
    r_phase(4'd1, 6'h0E, OKAY, 1'b0);
`endif

    // 6: reset after two beats of a four-beat write
    wbuf[0] = 64'hC0DE_0000; wbuf[1] = 64'hC0DE_0001;
    aw_phase(6'h33, 32'hC00, 4'd3, INCR);
    w_phase(4'd1, 8'hFF, 99);
    axi_rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctl", {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp}, 64'h0);
    check("midrst_ids", {bid, rid}, 64'h0);
    axi_rst = 1'b0;
    @(posedge clk); #1;
    exp_r[0] = 64'hC0DE_0000; exp_r[1] = 64'hC0DE_0001;
    ar_phase(6'h34, 32'hC00, 4'd1, INCR);
    r_phase(4'd1, 6'h34, OKAY, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
